// File: rtl/microwave_cook_controller.sv
// Sequencing controller for the M:SS countdown timer: keypad entry, load/count
// gating, start/stop/clear handling, door interlock and the done indication.
module microwave_cook_controller #(
  parameter int DONE_CYCLES = 5
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       load,
  output logic [3:0] load_min_units,
  output logic [2:0] load_sec_tens,
  output logic [3:0] load_sec_units,
  output logic       count_en,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state
);

  // Handshake: there is no valid/ready pair here. digit_valid is a one-cycle
  // strobe qualifying digit; start/stop/clear are levels sampled every cycle.

  localparam int CW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SET_TIME = 3'd1,
    S_COOKING  = 3'd2,
    S_PAUSED   = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      min_q, min_d;
  logic [2:0]      tens_q, tens_d;
  logic [3:0]      units_q, units_d;
  logic [CW-1:0]   dcnt_q, dcnt_d;
  logic            load_q, load_d;
  logic            cnt_q, cnt_d;
  logic            mag_q, mag_d;
  logic            done_q, done_d;
  logic            digit_ok;
  logic            take_digit;
  logic            clear_entry;
  logic            entry_zero;

  // A units digit above 5 cannot become a seconds-tens digit.
  assign digit_ok   = digit_valid && (digit <= 4'd9) && (units_q <= 4'd5);
  assign entry_zero = (min_q == 4'd0) && (tens_q == 3'd0) && (units_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    load_d      = 1'b0;
    take_digit  = 1'b0;
    clear_entry = 1'b0;
    if (clear) begin
      state_d     = S_IDLE;
      clear_entry = 1'b1;
      dcnt_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (stop) begin
            clear_entry = 1'b1;
          end else if (digit_ok) begin
            take_digit = 1'b1;
            state_d    = S_SET_TIME;
          end
        end
        S_SET_TIME: begin
          if (stop) begin
            state_d     = S_IDLE;
            clear_entry = 1'b1;
          end else if (start && door_closed && !entry_zero) begin
            state_d = S_COOKING;
            load_d  = 1'b1;
          end else begin
            take_digit = digit_ok;
          end
        end
        S_COOKING: begin
          // The timer has not been loaded yet in the load cycle, so its
          // zero flag is stale there.
          if (timer_zero && !load_q) begin
            state_d = S_DONE;
            dcnt_d  = '0;
          end else if (stop || !door_closed) begin
            state_d = S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (stop) begin
            state_d     = S_IDLE;
            clear_entry = 1'b1;
          end else if (start && door_closed) begin
            state_d = S_COOKING;
          end
        end
        S_DONE: begin
          if (dcnt_q == DONE_LAST) begin
            state_d     = S_IDLE;
            clear_entry = 1'b1;
            dcnt_d      = '0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: begin
          state_d     = S_IDLE;
          clear_entry = 1'b1;
          dcnt_d      = '0;
        end
      endcase
    end

    min_d   = min_q;
    tens_d  = tens_q;
    units_d = units_q;
    if (clear_entry) begin
      min_d   = 4'd0;
      tens_d  = 3'd0;
      units_d = 4'd0;
    end else if (take_digit) begin
      min_d   = {1'b0, tens_q};
      tens_d  = units_q[2:0];
      units_d = digit;
    end

    mag_d  = (state_d == S_COOKING);
    cnt_d  = (state_d == S_COOKING) && !load_d;
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      min_q   <= 4'd0;
      tens_q  <= 3'd0;
      units_q <= 4'd0;
      dcnt_q  <= '0;
      load_q  <= 1'b0;
      cnt_q   <= 1'b0;
      mag_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      dcnt_q  <= dcnt_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      done_q  <= done_d;
    end
  end

  assign load           = load_q;
  assign load_min_units = min_q;
  assign load_sec_tens  = tens_q;
  assign load_sec_units = units_q;
  assign count_en       = cnt_q;
  assign mag_on         = mag_q;
  assign done           = done_q;
  assign state          = state_q;

endmodule

// File: tb/tb_microwave_cook_controller.sv
// Bench for microwave_cook_controller: directed scenarios then random commands,
// checked each cycle against an arithmetic model of the cook-time entry and modes.
module tb_microwave_cook_controller;

  localparam int DC = 5;
  localparam int M_IDLE = 0, M_SET = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;

  logic       clk = 1'b0;
  logic       rst, dv, st, sp, cl, dc, tz;
  logic [3:0] dg;
  logic       load, count_en, mag_on, done;
  logic [3:0] mu, su;
  logic [2:0] stn;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // reference model: mode, cook time entry as a 3-digit decimal number
  int  md = M_IDLE;
  int  entry = 0;
  bit  first_cook = 0;
  int  done_left = 0;
  bit  e_load = 0, e_cnt = 0, e_mag = 0, e_done = 0;
  int  tmr = 0;
  logic [31:0] exp_q[$];

  microwave_cook_controller #(.DONE_CYCLES(DC)) dut (
    .CLK(clk), .Reset(rst), .digit_valid(dv), .digit(dg), .start(st),
    .stop(sp), .clear(cl), .door_closed(dc), .timer_zero(tz),
    .load(load), .load_min_units(mu), .load_sec_tens(stn), .load_sec_units(su),
    .count_en(count_en), .mag_on(mag_on), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit digit_accepted(input bit v, input int d);
    return v && d <= 9 && (entry % 10) <= 5;
  endfunction

  function automatic void model_step(input bit r, input bit v, input int d, input bit s,
                                     input bit p, input bit c, input bit door, input bit z);
    bit loaded = 0;
    if (r || c) begin
      md = M_IDLE;
      entry = 0;
    end else begin
      case (md)
        M_IDLE:
          if (p) entry = 0;
          else if (digit_accepted(v, d)) begin
            entry = (entry * 10 + d) % 1000;
            md = M_SET;
          end
        M_SET:
          if (p) begin md = M_IDLE; entry = 0; end
          else if (s && door && entry != 0) begin md = M_COOK; loaded = 1; end
          else if (digit_accepted(v, d)) entry = (entry * 10 + d) % 1000;
        M_COOK:
          if (z && !first_cook) begin md = M_DONE; done_left = DC; end
          else if (p || !door) md = M_PAUSE;
        M_PAUSE:
          if (p) begin md = M_IDLE; entry = 0; end
          else if (s && door) md = M_COOK;
        default:
          if (done_left == 1) begin md = M_IDLE; entry = 0; end
          else done_left--;
      endcase
    end
    first_cook = loaded;
    e_load = loaded;
    e_mag  = (md == M_COOK);
    e_cnt  = (md == M_COOK) && !loaded;
    e_done = (md == M_DONE);
  endfunction

  task automatic cyc(input bit r, input bit v, input int d, input bit s,
                     input bit p, input bit c, input bit door, input bit z);
    @(negedge clk);
    rst = r; dv = v; dg = d[3:0]; st = s; sp = p; cl = c; dc = door; tz = z;
    @(posedge clk);
    // environment timer, counting in whole seconds
    if (e_load) tmr = (entry / 100) * 60 + entry % 100;
    else if (e_cnt && tmr > 0) tmr--;
    model_step(r, v, d, s, p, c, door, z);
    exp_q.push_back(32'(md));
    exp_q.push_back(32'(entry / 100));
    exp_q.push_back(32'((entry / 10) % 10));
    exp_q.push_back(32'(entry % 10));
    #1;
    chk("state", 32'(state), exp_q.pop_front());
    chk("min_units", 32'(mu), exp_q.pop_front());
    chk("sec_tens", 32'(stn), exp_q.pop_front());
    chk("sec_units", 32'(su), exp_q.pop_front());
    chk("load", 32'(load), 32'(e_load));
    chk("count_en", 32'(count_en), 32'(e_cnt));
    chk("mag_on", 32'(mag_on), 32'(e_mag));
    chk("done", 32'(done), 32'(e_done));
  endtask

  task automatic idle(input int n, input bit door);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, door, 0);
  endtask

  task automatic key(input int d);
    cyc(0, 1, d, 0, 0, 0, 1, 0);
  endtask

  initial begin
    int n;
    rst = 1; dv = 0; dg = 0; st = 0; sp = 0; cl = 0; dc = 1; tz = 0;
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    // 1:30 entry, start, load pulse then counting
    key(1); key(3); key(0);
    chk("entry_130", {20'd0, mu, 1'b0, stn, su}, {20'd0, 4'd1, 1'b0, 3'd3, 4'd0});
    cyc(0, 0, 0, 1, 0, 0, 1, 0);
    chk("load_pulse", 32'(load), 32'd1);
    idle(3, 1);
    // door opens mid-cook, then resume without reload
    idle(1, 0);
    chk("door_pause", 32'(state), 32'd3);
    cyc(0, 0, 0, 1, 0, 0, 1, 0);
    chk("resume_noload", {30'd0, load, count_en}, 32'd1);
    idle(2, 1);
    // timer_zero with stop: zero wins, then done for DC cycles
    cyc(0, 0, 0, 0, 1, 0, 1, 1);
    chk("zero_beats_stop", 32'(state), 32'd4);
    n = 1;
    for (int i = 0; i < 10 && state == 3'd4; i++) begin
      idle(1, 1);
      if (done) n++;
    end
    chk("done_len", 32'(n), 32'(DC));
    // rejected digits
    key(12);
    chk("digit12_ignored", 32'(state), 32'd0);
    key(7); key(2);
    key(15); key(0);
    // clear mid-cook, then start on zero entry
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    key(4); key(5);
    cyc(0, 0, 0, 1, 0, 0, 1, 0);
    idle(2, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, 0);
    chk("start_zero_entry", 32'(state), 32'd0);
    // reset in DONE and in PAUSED
    key(2); cyc(0, 0, 0, 1, 0, 0, 1, 0); idle(1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    key(9); key(5); cyc(0, 0, 0, 1, 0, 0, 1, 0); idle(1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    // random command mix against the model
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
          $urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0,
          $urandom_range(0, 24) != 0, (tmr == 0) || ($urandom_range(0, 199) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/microwave_cook_controller.md
Name: microwave_cook_controller

Overview:
Sequencing controller for the minutes/seconds countdown timer in the microwave datapath.
- Collects keypad digits into a 3-digit BCD cook time (M:SS).
- Loads that time into the timer and gates the timer's count enable.
- Handles start/stop/clear commands and the door interlock.
- Drives the magnetron enable and a timed "done" beep.

Parameters:
DONE_CYCLES, 5, number of CLK cycles the done output stays high after the timer reaches zero (must be >= 1).

Ports:
CLK  input  1  system clock; all state changes on the rising edge.
Reset  input  1  synchronous reset, active-high.
digit_valid  input  1  one-cycle strobe, keypad digit present.
digit  input  4  BCD keypad digit; values 10-15 are ignored.
start  input  1  start/resume command, sampled each cycle.
stop  input  1  pause/cancel command, sampled each cycle.
clear  input  1  abort and clear command, sampled each cycle.
door_closed  input  1  1 = door closed (interlock satisfied).
timer_zero  input  1  from timer: all timer digits are zero.
load  output  1  one-cycle pulse; timer loads the load_* digits.
load_min_units  output  4  entered minutes digit, 0-9.
load_sec_tens  output  3  entered seconds tens digit, 0-5.
load_sec_units  output  4  entered seconds units digit, 0-9.
count_en  output  1  timer decrements one step per cycle while high.
mag_on  output  1  magnetron enable.
done  output  1  cook-complete indication.
state  output  3  current FSM state encoding, for debug and display.

Behaviour:
Clocking and reset:
- One clock, CLK.
- Reset is synchronous and active-high.
- All outputs are registered.
- Reset forces: state=IDLE, load=0, all load_* digits=0, count_en=0, mag_on=0, done=0, done counter=0.

State encoding:
- IDLE=0, SET_TIME=1, COOKING=2, PAUSED=3, DONE=4.

Command priority within a cycle, highest first:
- clear > timer_zero (COOKING only) > stop > door open > start > digit_valid.

Digit entry (IDLE and SET_TIME only; ignored in all other states):
- An accepted digit shifts left: min_units <= sec_tens, sec_tens <= sec_units, sec_units <= digit.
- A digit is rejected, with the register unchanged, when:
  - digit > 9, or
  - current sec_units > 5 (it would create seconds tens > 5).
- An accepted digit in IDLE moves the FSM to SET_TIME.
- A rejected digit in IDLE leaves the FSM in IDLE.
- Digits shifted past min_units are discarded.

IDLE:
- Entry register is zero. count_en=0, mag_on=0.
- start is ignored.

SET_TIME:
- start with door_closed=1 and a nonzero entry goes to COOKING, with the following timing:
  - load=1 during the first COOKING cycle.
  - count_en=0 in that cycle.
  - timer_zero is ignored in that cycle.
- start with the door open or an all-zero entry is ignored.
- stop returns to IDLE and clears the entry.

COOKING:
- mag_on=1 in every COOKING cycle.
- count_en=1 in every COOKING cycle except the load cycle.
- timer_zero=1 goes to DONE. This also applies when stop or door open occur in the same cycle.
- stop goes to PAUSED.
- door_closed=0 goes to PAUSED.
- mag_on and count_en drop in the first PAUSED cycle; there is no extra count.

PAUSED:
- count_en=0, mag_on=0.
- The timer holds its value; there is no reload.
- start with door_closed=1 goes to COOKING. No load pulse; count_en=1 immediately.
- stop goes to IDLE and clears the entry.

DONE:
- mag_on=0, count_en=0.
- done=1 for exactly DONE_CYCLES cycles, then the FSM goes to IDLE and the entry is cleared.
- Digits and start are ignored.

clear:
- From any state, goes to IDLE in the next cycle.
- Entry cleared, done=0, load=0.

Other rules:
- The load_* outputs reflect the entry register at all times.
- The entry register is retained through COOKING and PAUSED.
- A Reset asserted mid-cook takes effect on the next edge, the same as a clear.

Test Plan:
1. Reset; digits 1,3,0; start with door_closed=1 -> load_*=1/3/0; load pulse on the first COOKING cycle; count_en=1 from the next cycle; mag_on=1; state=2.
2. Digits 7 then 2 -> second digit rejected; load_sec_units=7, load_sec_tens=0. Digit 12 in IDLE -> ignored, state stays 0.
3. While COOKING, drop door_closed -> state=3 and count_en=0, mag_on=0 in the next cycle. Close the door and pulse start -> state=2 with no load pulse; count_en=1.
4. Drive timer_zero=1 together with stop in COOKING -> state=4; done=1 for exactly 5 cycles; then state=0 and load_*=0/0/0.
5. Pulse clear mid-COOKING -> state=0 next cycle; count_en=0, mag_on=0, entry zeroed. start with an all-zero entry -> no transition.
6. Reset asserted for one cycle in DONE and in PAUSED -> all outputs at reset values on the following cycle.
